// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous 32-bit SRAM between an instruction-fetch
// port (read only) and a data-memory port (read/write).
//
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   if_req/if_addr                  fetch request; if_ack pulses with if_rdata valid
//   dm_req/dm_wen/dm_addr/dm_wdata  data request (dm_wen==0 is a read)
//   dm_ack/dm_rdata                 data completion pulse and read data
//   sram_*                          SRAM address, data, byte enables and strobes
//   busy                            FSM not in IDLE
//
// Each access is IDLE(grant) -> READ x RD_WAIT -> RACK, or
// IDLE(grant) -> WRITE x WR_WAIT -> WHOLD. The ack comes from RACK/WHOLD.
module sram_arbiter #(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [19:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic [3:0]  dm_wen,
    input  logic [19:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic [19:0] sram_addr,
    input  logic [31:0] sram_dq_i,
    output logic [31:0] sram_dq_o,
    output logic        sram_dq_oe,
    output logic [3:0]  sram_be_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, READ, RACK, WRITE, WHOLD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_dm_q, last_dm_d;   // 1: data port was granted last
    logic        gnt_dm_q, gnt_dm_d;     // 1: current access belongs to data port
    logic [19:0] addr_q, addr_d;
    logic [3:0]  wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        pick_dm;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_dm_q  <= 1'b0;   // fetch "won last", so data wins the first tie
            gnt_dm_q   <= 1'b0;
            addr_q     <= '0;
            wen_q      <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_dm_q  <= last_dm_d;
            gnt_dm_q   <= gnt_dm_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_dm_d  = last_dm_q;
        gnt_dm_d   = gnt_dm_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        pick_dm    = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_be_n  = 4'hF;
        sram_dq_oe = 1'b0;
        if_ack     = 1'b0;
        dm_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    // Round-robin on contention: grant whoever did not go last.
                    pick_dm   = dm_req && (!if_req || !last_dm_q);
                    gnt_dm_d  = pick_dm;
                    last_dm_d = pick_dm;
                    cnt_d     = '0;
                    if (pick_dm) begin
                        addr_d  = dm_addr;
                        wen_d   = dm_wen;
                        wdata_d = dm_wdata;
                        state_d = (dm_wen == 4'h0) ? READ : WRITE;
                    end else begin
                        addr_d  = if_addr;
                        wen_d   = 4'h0;
                        state_d = READ;
                    end
                end
            end
            READ: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = 4'h0;
                if (cnt_q == 4'(RD_WAIT - 1)) begin
                    if (gnt_dm_q) dm_rdata_d = sram_dq_i;
                    else          if_rdata_d = sram_dq_i;
                    state_d = RACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RACK: begin
                if_ack  = !gnt_dm_q;
                dm_ack  = gnt_dm_q;
                state_d = IDLE;
            end
            WRITE: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_be_n  = ~wen_q;
                sram_dq_oe = 1'b1;
                if (cnt_q == 4'(WR_WAIT - 1)) state_d = WHOLD;
                else                          cnt_d   = cnt_q + 4'd1;
            end
            WHOLD: begin
                // we_n rises while address, enables and data stay driven (hold time).
                sram_ce_n  = 1'b0;
                sram_be_n  = ~wen_q;
                sram_dq_oe = 1'b1;
                dm_ack     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sram_addr = addr_q;
    assign sram_dq_o = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
